// File: rtl/sgd_scatter_tree_pkg.sv
// Shared widths and the level-0 learning-rate scaling helper for the scatter tree.
package sgd_scatter_tree_pkg;

  localparam int SGD_DATA_WIDTH = 32;
  localparam int DATA_W         = SGD_DATA_WIDTH;
  localparam int SHIFT_W        = 5;

  function automatic logic signed [DATA_W-1:0] scale_shift(
    input logic signed [DATA_W-1:0] x,
    input logic        [SHIFT_W-1:0] s
  );
    return x >>> s;
  endfunction

endpackage

// File: rtl/sgd_scatter_level.sv
// One fan-out register level: copy w loads source copy w/2 whenever the level advances.
module sgd_scatter_level
  import sgd_scatter_tree_pkg::*;
#(
  parameter int COPIES     = 2,
  parameter int SRC_COPIES = 1,
  parameter int LVL_W      = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adv,
  input  logic [SRC_COPIES*LVL_W-1:0]   src_data,
  input  logic                          src_vld,
  output logic [COPIES*LVL_W-1:0]       data,
  output logic                          vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (adv) begin
      vld <= src_vld;
      for (int w = 0; w < COPIES; w++) begin
        data[w*LVL_W +: LVL_W] <= src_data[(w/2)*LVL_W +: LVL_W];
      end
    end
  end

endmodule

// File: rtl/sgd_scatter_tree.sv
// Pipelined broadcast tree with valid/ready backpressure and an output transfer counter.
// Optional build macro: SGD_SCATTER_SHIFT_EN adds v_shift and scales the input at level 0.
module sgd_scatter_tree
  import sgd_scatter_tree_pkg::*;
#(
  parameter int TREE_DEPTH = 3,
  parameter int TREE_WIDTH = 2**TREE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] v_input,
  input  logic                     v_input_valid,
  output logic                     v_input_ready,
`ifdef SGD_SCATTER_SHIFT_EN
  input  logic [SHIFT_W-1:0]       v_shift,
`endif
  output logic signed [DATA_W-1:0] v_output [TREE_WIDTH-1:0],
  output logic                     v_output_valid,
  input  logic                     v_output_ready,
  output logic [31:0]              v_xfer_cnt
);

  localparam int TOTAL_COPIES = 2**(TREE_DEPTH+1) - 2;
  localparam int LAST_OFF     = (2**TREE_DEPTH - 2) * DATA_W;

  logic [TOTAL_COPIES*DATA_W-1:0] lvl_bus;
  logic [TREE_DEPTH-1:0]          lvl_valid;
  logic [TREE_DEPTH-1:0]          adv;
  logic signed [DATA_W-1:0]       lvl0_in;
  logic [31:0]                    cnt_q;

`ifdef SGD_SCATTER_SHIFT_EN
  assign lvl0_in = scale_shift(v_input, v_shift);
`else
  assign lvl0_in = v_input;
`endif

  // A level may advance if it or any level downstream of it holds a bubble.
  always_comb begin
    for (int d = 0; d < TREE_DEPTH; d++) begin
      logic a;
      a = v_output_ready;
      for (int k = d; k < TREE_DEPTH; k++) a = a | ~lvl_valid[k];
      adv[d] = a;
    end
  end

  assign v_input_ready = adv[0];

  for (genvar d = 0; d < TREE_DEPTH; d++) begin : g_lvl
    localparam int COPIES = 2**(d+1);
    localparam int SRC    = (d == 0) ? 1 : 2**d;
    localparam int OFF    = (2**(d+1) - 2) * DATA_W;
    logic [SRC*DATA_W-1:0] src;
    logic                  src_vld;

    // Stage d: source is the input port for the first level, else the previous level.
    if (d == 0) begin : g_src_in
      assign src     = lvl0_in;
      assign src_vld = v_input_valid;
    end else begin : g_src_prev
      assign src     = lvl_bus[(2**d - 2)*DATA_W +: SRC*DATA_W];
      assign src_vld = lvl_valid[d-1];
    end

    sgd_scatter_level #(
      .COPIES     (COPIES),
      .SRC_COPIES (SRC),
      .LVL_W      (DATA_W)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv[d]),
      .src_data (src),
      .src_vld  (src_vld),
      .data     (lvl_bus[OFF +: COPIES*DATA_W]),
      .vld      (lvl_valid[d])
    );
  end

  for (genvar w = 0; w < TREE_WIDTH; w++) begin : g_out
    assign v_output[w] = lvl_bus[LAST_OFF + w*DATA_W +: DATA_W];
  end

  assign v_output_valid = lvl_valid[TREE_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v_output_valid && v_output_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign v_xfer_cnt = cnt_q;

endmodule

// File: tb/tb_sgd_scatter_tree.sv
// Randomized bench for sgd_scatter_tree checked against a queue-based transfer model.
module tb_sgd_scatter_tree;

  localparam int DEPTH = 3;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] v_input = '0;
  logic               v_input_valid = 1'b0;
  logic               v_input_ready;
  logic [4:0]         sh = '0;
  logic signed [31:0] v_output [WIDTH-1:0];
  logic               v_output_valid;
  logic               v_output_ready = 1'b0;
  logic [31:0]        v_xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  logic [31:0] mcnt = '0;
  logic        chk_en = 1'b0;
  int          n_acc_rand = 0;

  sgd_scatter_tree #(.TREE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .v_input        (v_input),
    .v_input_valid  (v_input_valid),
    .v_input_ready  (v_input_ready),
`ifdef SGD_SCATTER_SHIFT_EN
    .v_shift        (sh),
`endif
    .v_output       (v_output),
    .v_output_valid (v_output_valid),
    .v_output_ready (v_output_ready),
    .v_xfer_cnt     (v_xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_in(input logic [31:0] x, input logic [4:0] s);
`ifdef SGD_SCATTER_SHIFT_EN
    return $signed(x) >>> s;
`else
    return x + 32'd0 * s;
`endif
  endfunction

  // Transfer-level model: everything accepted and not yet delivered is in flight.
  always @(negedge clk) begin
    if (chk_en) begin
      check("xfer_cnt", v_xfer_cnt, mcnt);
      check("in_ready", {31'd0, v_input_ready},
            {31'd0, (q.size() < DEPTH) || v_output_ready});
      if (v_output_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", {31'd0, v_output_valid}, 32'd0);
        end else if (v_output_ready) begin
          for (int w = 0; w < WIDTH; w++) check($sformatf("lane%0d", w), v_output[w], q[0]);
          void'(q.pop_front());
          mcnt = mcnt + 32'd1;
        end
      end
      if (v_input_valid && v_input_ready) q.push_back(model_in(v_input, sh));
    end
  end

  task automatic step(input logic vld, input logic [31:0] d, input logic [4:0] s,
                      input logic ordy, output logic acc);
    v_input_valid  = vld;
    v_input        = d;
    sh             = s;
    v_output_ready = ordy;
    @(negedge clk);
    acc = vld && v_input_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    end
    check("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] d, snap;
    logic [4:0]  s;
    logic        vld;
    int          idx;

    #3;
    check("rst_out_valid", {31'd0, v_output_valid}, 32'd0);
    check("rst_in_ready", {31'd0, v_input_ready}, 32'd1);
    check("rst_cnt", v_xfer_cnt, 32'd0);
    for (int w = 0; w < WIDTH; w++) check("rst_lane", v_output[w], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single value latency: accepted at edge N, visible after edge N+2.
    step(1'b1, 32'h0000_1234, 5'd0, 1'b1, acc);
    check("single_acc", {31'd0, acc}, 32'd1);
    v_input_valid = 1'b0;
    check("lat_n0", {31'd0, v_output_valid}, 32'd0);
    step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    check("lat_n1", {31'd0, v_output_valid}, 32'd0);
    step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    check("lat_n2", {31'd0, v_output_valid}, 32'd1);
    for (int w = 0; w < WIDTH; w++) check("single_lane", v_output[w], 32'h0000_1234);
    step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    check("single_cnt", v_xfer_cnt, 32'd1);

    // Streaming with downstream always ready.
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, $urandom, 5'd0, 1'b1, acc);
      check("stream_ready", {31'd0, acc}, 32'd1);
    end
    drain();
    check("stream_cnt", v_xfer_cnt, 32'd1001);

    // Backpressure: fill, hold for 10 cycles, then release.
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hA000_0000 + idx, 5'd0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_fill", idx, DEPTH);
    snap = v_output[0];
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hA000_0000 + idx, 5'd0, 1'b0, acc);
      check("bp_no_accept", {31'd0, acc}, 32'd0);
      check("bp_in_ready", {31'd0, v_input_ready}, 32'd0);
      check("bp_frozen", v_output[0], snap);
      check("bp_valid", {31'd0, v_output_valid}, 32'd1);
    end
    step(1'b1, 32'hA000_0000 + idx, 5'd0, 1'b1, acc);
    check("bp_release_acc", {31'd0, acc}, 32'd1);
    drain();
    check("bp_cnt", v_xfer_cnt, 32'd1005);

    // Random valid/ready; upstream holds its value until accepted.
    vld = 1'b0; d = '0; s = '0; acc = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (acc || !vld) begin
        vld = 1'($urandom_range(0, 1));
        d   = $urandom;
        s   = 5'($urandom_range(0, 31));
      end
      step(vld, d, s, 1'($urandom_range(0, 1)), acc);
      if (acc) n_acc_rand++;
    end
    drain();
    check("rand_cnt", v_xfer_cnt, 32'd1005 + n_acc_rand);

    // Asynchronous reset with a full pipe.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h5500_0000 + i, 5'd0, 1'b0, acc);
    check("ar_full", q.size(), DEPTH);
    chk_en = 1'b0;
    v_input_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, v_output_valid}, 32'd0);
    check("ar_cnt", v_xfer_cnt, 32'd0);
    check("ar_in_ready", {31'd0, v_input_ready}, 32'd1);
    for (int w = 0; w < WIDTH; w++) check("ar_lane", v_output[w], 32'd0);
    q.delete();
    mcnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    check("ar_no_output", v_xfer_cnt, 32'd0);

`ifdef SGD_SCATTER_SHIFT_EN
    step(1'b1, 32'hFFFF_FF00, 5'd4, 1'b1, acc);
    v_input_valid = 1'b0;
    step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    step(1'b0, 32'd0, 5'd0, 1'b1, acc);
    for (int w = 0; w < WIDTH; w++) check("shift_lane", v_output[w], 32'hFFFF_FFF0);
    drain();
`endif

    // Counter wrap from all-ones.
    force dut.cnt_q = 32'hFFFF_FFFF;
    mcnt = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    step(1'b1, 32'h0000_0077, 5'd0, 1'b1, acc);
    drain();
    check("wrap_cnt", v_xfer_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
